// File: rtl/code_decoder_pkg.sv
// rtl/code_decoder_pkg.sv - shared widths, FSM encoding and one-hot helper for code_decoder
package code_decoder_pkg;

   localparam int CODE_W_DEF = 3;
   localparam int N_OUT_DEF  = 2 ** CODE_W_DEF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_OFFER = 2'd2
   } state_e;

   // A cleared flag means no encoder input was active, so nothing lights up
   function automatic logic [N_OUT_DEF-1:0] onehot(input logic [CODE_W_DEF-1:0] code,
                                                   input logic                  flag);
      onehot = '0;
      if (flag) begin
         onehot[code] = 1'b1;
      end
   endfunction

endpackage

// File: rtl/code_decoder_if.sv
// rtl/code_decoder_if.sv - upstream code stream and downstream one-hot stream of code_decoder
interface code_decoder_if #(
   parameter int CODE_W = 3
);
   localparam int N_OUT = 2 ** CODE_W;

   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] in_code;
   logic              in_flag;
   logic              out_valid;
   logic              out_ready;
   logic [N_OUT-1:0]  out_onehot;
   logic              out_flag;

   modport slave (
      input  in_valid, in_code, in_flag, out_ready,
      output in_ready, out_valid, out_onehot, out_flag
   );

   modport master (
      output in_valid, in_code, in_flag, out_ready,
      input  in_ready, out_valid, out_onehot, out_flag
   );

endinterface

// File: rtl/code_fifo.sv
// rtl/code_fifo.sv - small synchronous FIFO; ready_o is a registered not-full flag
module code_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         empty_o,
   output logic         ready_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          ready_q;
   logic          do_push, do_pop;

   // Push only sees the registered ready, so a pop on a full FIFO cannot admit a word that cycle
   assign do_push = push_i && ready_q;
   assign do_pop  = pop_i && (count_q != '0);
   assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         ready_q <= (count_d != (AW+1)'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign ready_o = ready_q;

endmodule

// File: rtl/code_decoder.sv
// rtl/code_decoder.sv - one-hot decoder: FIFO, display hold timer and downstream offer FSM
module code_decoder
   import code_decoder_pkg::*;
#(
   parameter int CODE_W = CODE_W_DEF,
   parameter int DEPTH  = 2,
   parameter int HOLD   = 4
) (
   input  logic             clk,
   input  logic             rst,
   code_decoder_if.slave    bus,
   output logic [7:0]       word_cnt,
   output logic             busy
);
   localparam int N_OUT  = 2 ** CODE_W;
   localparam int FW     = CODE_W + 1;
   localparam int HCNT_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
   localparam logic [HCNT_W-1:0] HLOAD = (HOLD > 0) ? HCNT_W'(HOLD - 1) : '0;

   state_e            state_q, state_d;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;
   logic [N_OUT-1:0]  onehot_q, onehot_d;
   logic              flag_q, flag_d;
   logic [7:0]        word_cnt_q, word_cnt_d;

   logic [FW-1:0]     fifo_rdata;
   logic              fifo_empty;
   logic              fifo_ready;
   logic              fifo_pop;
   logic              load;

   code_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.in_valid),
      .wdata_i ({bus.in_code, bus.in_flag}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .ready_o (fifo_ready)
   );

   always_comb begin
      state_d    = state_q;
      hcnt_d     = hcnt_q;
      onehot_d   = onehot_q;
      flag_d     = flag_q;
      word_cnt_d = word_cnt_q;
      load       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            load = !fifo_empty;
         end
         ST_HOLD: begin
            if (hcnt_q == '0) state_d = ST_OFFER;
            else              hcnt_d  = hcnt_q - 1'b1;
         end
         ST_OFFER: begin
            if (bus.out_ready) begin
               word_cnt_d = word_cnt_q + 8'd1;
               if (!fifo_empty) load    = 1'b1;
               else             state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Reloading straight out of OFFER is what gives one word per HOLD+1 cycles
      if (load) begin
         onehot_d = onehot(fifo_rdata[FW-1:1], fifo_rdata[0]);
         flag_d   = fifo_rdata[0];
         if (HOLD == 0) begin
            state_d = ST_OFFER;
         end else begin
            state_d = ST_HOLD;
            hcnt_d  = HLOAD;
         end
      end
      fifo_pop = load;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         hcnt_q     <= '0;
         onehot_q   <= '0;
         flag_q     <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hcnt_q     <= hcnt_d;
         onehot_q   <= onehot_d;
         flag_q     <= flag_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign bus.in_ready   = fifo_ready;
   assign bus.out_valid  = (state_q == ST_OFFER);
   assign bus.out_onehot = onehot_q;
   assign bus.out_flag   = flag_q;
   assign word_cnt       = word_cnt_q;
   assign busy           = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_code_decoder.sv
// tb/tb_code_decoder.sv - directed vector bench for code_decoder with output scoreboard
module tb_code_decoder;

   localparam int HOLD = 4;

   typedef struct {
      logic [2:0] code;
      logic       flag;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      logic [7:0] onehot;
      logic       flag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] word_cnt;
   logic       busy;
   int         n_cmp  = 0;
   int         n_fail = 0;
   int         cyc    = 0;

   exp_t exp_q[$];
   int   hs_times[$];
   vec_t vecs[16];

   code_decoder_if #(.CODE_W(3)) bus ();

   code_decoder #(.CODE_W(3), .DEPTH(2), .HOLD(HOLD)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .word_cnt (word_cnt),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Handshakes and offer stability are judged just after the falling edge,
   // once the main thread has settled the inputs for the next rising edge.
   logic       pv = 1'b0, pr = 1'b0, prst = 1'b1;
   logic [7:0] poh = '0;
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (pv && !pr && !prst) begin
         check("valid_stable", 32'(bus.out_valid), 32'd1);
         check("data_stable", 32'(bus.out_onehot), 32'(poh));
      end
      if (bus.out_valid && bus.out_ready && !rst) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h want none", bus.out_onehot);
         end else begin
            e = exp_q.pop_front();
            check("out_onehot", 32'(bus.out_onehot), 32'(e.onehot));
            check("out_flag", 32'(bus.out_flag), 32'(e.flag));
         end
         hs_times.push_back(cyc);
      end
      pv   = bus.out_valid;
      pr   = bus.out_ready;
      prst = rst;
      poh  = bus.out_onehot;
   end

   // Called at a falling edge; returns at the falling edge after the word was taken
   task automatic push_word(input logic [2:0] c, input logic f);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_code  = c;
      bus.in_flag  = f;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) check("push_timeout", 32'd0, 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((busy || bus.out_valid || exp_q.size() != 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(busy || bus.out_valid || exp_q.size() != 0), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{3'd0, 1'b0, 8'h00};  vecs[1]  = '{3'd0, 1'b1, 8'h01};
      vecs[2]  = '{3'd1, 1'b0, 8'h00};  vecs[3]  = '{3'd1, 1'b1, 8'h02};
      vecs[4]  = '{3'd2, 1'b0, 8'h00};  vecs[5]  = '{3'd2, 1'b1, 8'h04};
      vecs[6]  = '{3'd3, 1'b0, 8'h00};  vecs[7]  = '{3'd3, 1'b1, 8'h08};
      vecs[8]  = '{3'd4, 1'b0, 8'h00};  vecs[9]  = '{3'd4, 1'b1, 8'h10};
      vecs[10] = '{3'd5, 1'b0, 8'h00};  vecs[11] = '{3'd5, 1'b1, 8'h20};
      vecs[12] = '{3'd6, 1'b0, 8'h00};  vecs[13] = '{3'd6, 1'b1, 8'h40};
      vecs[14] = '{3'd7, 1'b0, 8'h00};  vecs[15] = '{3'd7, 1'b1, 8'h80};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_code   = '0;
      bus.in_flag   = 1'b0;
      bus.out_ready = 1'b0;

      // Reset: two cycles high, then outputs cleared and in_ready up one cycle later
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready_up", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_onehot", 32'(bus.out_onehot), 32'd0);
      check("rst_flag", 32'(bus.out_flag), 32'd0);
      check("rst_word_cnt", 32'(word_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Single word: pattern two cycles after push, out_valid HOLD cycles later
      bus.out_ready = 1'b1;
      exp_q.push_back('{8'h20, 1'b1});
      push_word(3'd5, 1'b1);
      check("single_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("single_pattern", 32'(bus.out_onehot), 32'h20);
      check("single_hold_valid", 32'(bus.out_valid), 32'd0);
      repeat (3) @(negedge clk);
      check("single_valid_early", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("single_valid", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
      check("single_valid_drop", 32'(bus.out_valid), 32'd0);
      check("single_cnt", 32'(word_cnt), 32'd1);

      // Flag-off word decodes to all zeros but is still counted
      exp_q.push_back('{8'h00, 1'b0});
      push_word(3'd3, 1'b0);
      @(negedge clk);
      check("flagoff_onehot", 32'(bus.out_onehot), 32'h00);
      check("flagoff_flag", 32'(bus.out_flag), 32'd0);
      wait_idle();
      check("flagoff_cnt", 32'(word_cnt), 32'd2);

      // Backpressure: word 0 parked in OFFER, 1 and 2 fill the FIFO, 3 refused
      bus.out_ready = 1'b0;
      exp_q.push_back('{8'h01, 1'b1});
      exp_q.push_back('{8'h02, 1'b1});
      exp_q.push_back('{8'h04, 1'b1});
      push_word(3'd0, 1'b1);
      push_word(3'd1, 1'b1);
      push_word(3'd2, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_code  = 3'd3;
      bus.in_flag  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("full_in_ready", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      check("bp_offer_valid", 32'(bus.out_valid), 32'd1);
      check("bp_offer_data", 32'(bus.out_onehot), 32'h01);
      // Same-cycle pop on a full FIFO must still refuse this push
      hs_times.delete();
      bus.out_ready = 1'b1;
      bus.in_code   = 3'd7;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("ready_after_pop", 32'(bus.in_ready), 32'd1);
      wait_idle();
      check("bp_hs_count", 32'(hs_times.size()), 32'd3);
      if (hs_times.size() == 3) begin
         check("bp_spacing_1", 32'(hs_times[1] - hs_times[0]), 32'(HOLD + 1));
         check("bp_spacing_2", 32'(hs_times[2] - hs_times[1]), 32'(HOLD + 1));
      end
      check("bp_cnt", 32'(word_cnt), 32'd5);

      // Sweep of every {code, flag} word back to back
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back('{vecs[i].exp, vecs[i].flag});
         push_word(vecs[i].code, vecs[i].flag);
      end
      wait_idle();
      check("sweep_cnt", 32'(word_cnt), 32'd21);

      // Counter wrap over 256 words from a fresh reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("wrap_start_cnt", 32'(word_cnt), 32'd0);
      for (int i = 0; i < 255; i++) begin
         exp_q.push_back('{8'(8'd1 << (i % 8)), 1'b1});
         push_word(3'(i % 8), 1'b1);
      end
      wait_idle();
      check("wrap_cnt_255", 32'(word_cnt), 32'd255);
      exp_q.push_back('{8'h80, 1'b1});
      push_word(3'd7, 1'b1);
      wait_idle();
      check("wrap_cnt_0", 32'(word_cnt), 32'd0);

      // Reset while offering with two words queued drops everything silently
      bus.out_ready = 1'b0;
      exp_q.push_back('{8'h08, 1'b1});
      exp_q.push_back('{8'h10, 1'b1});
      exp_q.push_back('{8'h20, 1'b1});
      push_word(3'd3, 1'b1);
      push_word(3'd4, 1'b1);
      push_word(3'd5, 1'b1);
      for (int n = 0; n < 20 && !bus.out_valid; n++) @(negedge clk);
      check("mid_offer_valid", 32'(bus.out_valid), 32'd1);
      check("mid_offer_full", 32'(bus.in_ready), 32'd0);
      rst           = 1'b1;
      bus.out_ready = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_cnt", 32'(word_cnt), 32'd0);
      check("mid_rst_onehot", 32'(bus.out_onehot), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      check("mid_rst_empty", 32'(busy), 32'd0);
      repeat (10) @(negedge clk);
      check("mid_rst_quiet", 32'(bus.out_valid), 32'd0);
      check("mid_rst_cnt_end", 32'(word_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
